// File: rtl/store_align_buffer.sv
// store_align_buffer: aligns sb/sh/sw stores into word writes with byte
// enables, queues them in a small FIFO and drains them in order to data
// memory over a req/ack handshake.
module store_align_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [1:0]               info_store,
    input  logic [31:0]              st_data,
    output logic                     misalign,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ack,
    output logic                     buf_empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } entry_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t         state, state_d;
    entry_t         fifo_mem [DEPTH];
    logic [PW-1:0]  wr_ptr, wr_ptr_d;
    logic [PW-1:0]  rd_ptr, rd_ptr_d;
    logic [CW-1:0]  count_d;
    logic [CW-1:0]  remain;

    logic [1:0]     off;
    logic [3:0]     al_be;
    logic [31:0]    al_wdata;
    logic           al_store;
    logic           al_mis;
    entry_t         new_entry;
    entry_t         head_d;
    entry_t         out_d;

    logic           accept;
    logic           enq;
    logic           mis_acc;
    logic           pop;

    // Lane alignment and misalignment detection for the incoming store
    always_comb begin
        al_be    = 4'b0000;
        al_wdata = 32'h0;
        al_store = 1'b0;
        al_mis   = 1'b0;
        off      = st_addr[1:0];
        case (info_store)
            2'b00: begin
                al_store = 1'b1;
                al_be    = 4'b0001 << off;
                al_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                if (off == 2'd3) begin
                    al_mis = 1'b1;
                end else begin
                    al_store = 1'b1;
                    al_be    = 4'b0011 << off;
                    al_wdata = {16'h0, st_data[15:0]} << {off, 3'b000};
                end
            end
            2'b10: begin
                if (off != 2'd0) begin
                    al_mis = 1'b1;
                end else begin
                    al_store = 1'b1;
                    al_be    = 4'hF;
                    al_wdata = st_data;
                end
            end
            default: begin
            end
        endcase
        new_entry = '{addr: {st_addr[AW-1:2], 2'b00}, wdata: al_wdata, be: al_be};
    end

    assign accept  = st_valid & st_ready;
    assign enq     = accept & al_store;
    assign mis_acc = accept & al_mis;
    assign mem_req = (state == S_REQ);

    // Drain FSM next state, pointer/count update and next memory-side outputs
    always_comb begin
        state_d  = state;
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        pop      = 1'b0;

        case (state)
            S_IDLE:  pop = 1'b0;
            S_REQ:   pop = mem_ack;
            default: pop = 1'b0;
        endcase

        if (enq) begin
            wr_ptr_d = wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr + PW'(1);
        end

        remain  = count - CW'(pop);
        count_d = remain + CW'(enq);

        // A store written this cycle into an otherwise empty queue is not yet
        // readable from the array, so present it directly.
        if (remain == CW'(0)) begin
            head_d = new_entry;
        end else begin
            head_d = fifo_mem[rd_ptr_d];
        end

        case (state)
            S_IDLE: begin
                if (count_d != CW'(0)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (pop && (count_d == CW'(0))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_d = (state_d == S_REQ) ? head_d : '0;
    end

    // State, pointers, count and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            st_ready  <= 1'b1;
            buf_empty <= 1'b1;
            misalign  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state     <= state_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            count     <= count_d;
            st_ready  <= (count_d != CW'(DEPTH));
            buf_empty <= (count_d == CW'(0));
            misalign  <= mis_acc;
            mem_addr  <= out_d.addr;
            mem_wdata <= out_d.wdata;
            mem_be    <= out_d.be;
        end
    end

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= new_entry;
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: alignment, misalignment, full/backpressure,
// simultaneous enqueue/pop, async reset and ignored stores.
module tb_store_align_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   st_valid;
    logic                   st_ready;
    logic [AW-1:0]          st_addr;
    logic [1:0]             info_store;
    logic [31:0]            st_data;
    logic                   misalign;
    logic                   mem_req;
    logic [AW-1:0]          mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_be;
    logic                   mem_ack;
    logic                   buf_empty;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_errors = 0;

    store_align_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .info_store (info_store),
        .st_data    (st_data),
        .misalign   (misalign),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .buf_empty  (buf_empty),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [1:0] info, input logic [31:0] d);
        st_valid   = 1'b1;
        st_addr    = a;
        info_store = info;
        st_data    = d;
    endtask

    task automatic drive_idle();
        st_valid   = 1'b0;
        st_addr    = '0;
        info_store = 2'b11;
        st_data    = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        drive_idle();
        tick();
        tick();

        // Reset values
        check("rst_st_ready",  64'(st_ready),  64'd1);
        check("rst_buf_empty", 64'(buf_empty), 64'd1);
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_misalign",  64'(misalign),  64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        rst_n = 1'b1;
        tick();

        // T1: sb at 0x103, ack in the second request cycle
        drive_st(32'h0000_0103, 2'b00, 32'h0000_00A5);
        tick();
        drive_idle();
        check("t1_req",     64'(mem_req),   64'd1);
        check("t1_addr",    64'(mem_addr),  64'h100);
        check("t1_be",      64'(mem_be),    64'h8);
        check("t1_wdata",   64'(mem_wdata), 64'hA5A5_A5A5);
        check("t1_count",   64'(count),     64'd1);
        check("t1_nempty",  64'(buf_empty), 64'd0);
        tick();
        check("t1_req_hold",  64'(mem_req),  64'd1);
        check("t1_addr_hold", 64'(mem_addr), 64'h100);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t1_req_done", 64'(mem_req),   64'd0);
        check("t1_empty",    64'(buf_empty), 64'd1);
        check("t1_count0",   64'(count),     64'd0);
        check("t1_addr0",    64'(mem_addr),  64'd0);

        // T2: sh at off 1, then misaligned sh and sw
        drive_st(32'h0000_0201, 2'b01, 32'h1234_BEEF);
        tick();
        check("t2_addr",  64'(mem_addr),  64'h200);
        check("t2_be",    64'(mem_be),    64'h6);
        check("t2_wdata", 64'(mem_wdata), 64'h00BE_EF00);
        check("t2_mis0",  64'(misalign),  64'd0);
        drive_st(32'h0000_0203, 2'b01, 32'h0000_5555);
        tick();
        check("t2_sh_mis",   64'(misalign), 64'd1);
        check("t2_sh_count", 64'(count),    64'd1);
        drive_st(32'h0000_0206, 2'b10, 32'hDEAD_BEEF);
        tick();
        drive_idle();
        check("t2_sw_mis",   64'(misalign), 64'd1);
        check("t2_sw_count", 64'(count),    64'd1);
        check("t2_head_kept", 64'(mem_addr), 64'h200);
        tick();
        check("t2_mis_pulse", 64'(misalign), 64'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t2_drained", 64'(count), 64'd0);

        // T3: fill with ack held low, fifth store waits for space
        for (int i = 0; i < 4; i++) begin
            drive_st(32'h300 + 32'(4 * i), 2'b10, 32'h1111_1111 * 32'(i + 1));
            tick();
        end
        check("t3_count_full", 64'(count),    64'd4);
        check("t3_not_ready",  64'(st_ready), 64'd0);
        drive_st(32'h0000_0310, 2'b10, 32'h5555_5555);
        tick();
        check("t3_blocked_count", 64'(count),    64'd4);
        check("t3_head0_addr",    64'(mem_addr), 64'h300);
        mem_ack = 1'b1;
        tick();
        check("t3_w1_addr",  64'(mem_addr),  64'h304);
        check("t3_w1_data",  64'(mem_wdata), 64'h2222_2222);
        check("t3_ready_up", 64'(st_ready),  64'd1);
        check("t3_cnt3a",    64'(count),     64'd3);
        tick();
        drive_idle();
        check("t3_w2_addr", 64'(mem_addr), 64'h308);
        check("t3_cnt3b",   64'(count),    64'd3);
        tick();
        check("t3_w3_addr", 64'(mem_addr), 64'h30C);
        check("t3_cnt2",    64'(count),    64'd2);
        tick();
        check("t3_w4_addr", 64'(mem_addr),  64'h310);
        check("t3_w4_data", 64'(mem_wdata), 64'h5555_5555);
        check("t3_cnt1",    64'(count),     64'd1);
        tick();
        mem_ack = 1'b0;
        check("t3_req_done", 64'(mem_req),   64'd0);
        check("t3_empty",    64'(buf_empty), 64'd1);

        // T4: enqueue and ack together with one entry in flight
        drive_st(32'h0000_0400, 2'b10, 32'hAAAA_0000);
        tick();
        check("t4_req", 64'(mem_req), 64'd1);
        drive_st(32'h0000_0404, 2'b10, 32'hBBBB_0000);
        mem_ack = 1'b1;
        tick();
        drive_idle();
        check("t4_count",  64'(count),     64'd1);
        check("t4_req2",   64'(mem_req),   64'd1);
        check("t4_addr2",  64'(mem_addr),  64'h404);
        check("t4_data2",  64'(mem_wdata), 64'hBBBB_0000);
        check("t4_nempty", 64'(buf_empty), 64'd0);
        tick();
        mem_ack = 1'b0;
        check("t4_count0", 64'(count), 64'd0);

        // T5: async reset with three queued stores
        for (int i = 0; i < 3; i++) begin
            drive_st(32'h500 + 32'(4 * i), 2'b10, 32'h7000_0000 + 32'(i));
            tick();
        end
        drive_idle();
        check("t5_count3", 64'(count),   64'd3);
        check("t5_req",    64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_req",   64'(mem_req),   64'd0);
        check("t5_rst_count", 64'(count),     64'd0);
        check("t5_rst_empty", 64'(buf_empty), 64'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_stale_req", 64'(mem_req), 64'd0);
        end
        check("t5_count_after", 64'(count), 64'd0);

        // T6: info_store=11 is ignored
        drive_st(32'h0000_0601, 2'b11, 32'hFFFF_FFFF);
        tick();
        drive_idle();
        check("t6_count", 64'(count),     64'd0);
        check("t6_mis",   64'(misalign),  64'd0);
        check("t6_req",   64'(mem_req),   64'd0);
        check("t6_empty", 64'(buf_empty), 64'd1);

        // sh at offset 2 lands in the upper half
        drive_st(32'h0000_0702, 2'b01, 32'h9999_CAFE);
        tick();
        drive_idle();
        check("sh2_be",    64'(mem_be),    64'hC);
        check("sh2_wdata", 64'(mem_wdata), 64'hCAFE_0000);
        check("sh2_addr",  64'(mem_addr),  64'h700);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sh2_drained", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
